// File: rtl/mem_access_unit.sv
// LC-3 memory-access stage: MARMUX, MAR/MDR, memory handshake FSM producing R,
// and the memory-mapped keyboard/display registers.
module mem_access_unit #(
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_MarMuxControl,
    input  logic [15:0] i_AdderMuxs,
    input  logic [7:0]  i_IR_7_0,
    output logic [15:0] o_MarMux_Out,
    input  logic [15:0] i_Bus,
    input  logic        i_LD_MAR,
    input  logic        i_LD_MDR,
    input  logic        i_MIO_EN,
    input  logic        i_R_W,
    output logic        o_R,
    output logic [15:0] o_MAR,
    output logic [15:0] o_MDR,
    output logic        o_Mem_Req,
    output logic        o_Mem_We,
    output logic [15:0] o_Mem_Addr,
    output logic [15:0] o_Mem_WData,
    input  logic        i_Mem_Ack,
    input  logic [15:0] i_Mem_RData,
    input  logic        i_KB_Valid,
    input  logic [7:0]  i_KB_Data,
    output logic        o_Disp_Valid,
    output logic [7:0]  o_Disp_Data,
    input  logic        i_Disp_Ready
);

    typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_DONE} state_e;

    state_e      state_q, state_d;
    logic        rw_q, rw_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic        kbsr_q, kbsr_d;
    logic [7:0]  kbdr_q, kbdr_d;
    logic        disp_valid_q, disp_valid_d;
    logic [7:0]  disp_data_q, disp_data_d;

    logic        start;
    logic        is_io;
    logic        io_rd;
    logic        io_wr;
    logic        kbdr_rd;
    logic [15:0] io_rdata;

    assign o_MarMux_Out = i_MarMuxControl ? i_AdderMuxs : {8'h00, i_IR_7_0};

    // I/O accesses are resolved entirely on the start edge; only RAM goes to MEM.
    assign start   = (state_q == ST_IDLE) && i_MIO_EN;
    assign is_io   = (mar_q == KBSR_ADDR) || (mar_q == KBDR_ADDR) ||
                     (mar_q == DSR_ADDR)  || (mar_q == DDR_ADDR);
    assign io_rd   = start && is_io && !i_R_W && i_LD_MDR;
    assign io_wr   = start && is_io && i_R_W;
    assign kbdr_rd = io_rd && (mar_q == KBDR_ADDR);

    always_comb begin
        io_rdata = 16'h0000;
        if (mar_q == KBSR_ADDR)      io_rdata = {kbsr_q, 15'b0};
        else if (mar_q == KBDR_ADDR) io_rdata = {8'h00, kbdr_q};
        else if (mar_q == DSR_ADDR)  io_rdata = {~disp_valid_q, 15'b0};
    end

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        mar_d        = mar_q;
        mdr_d        = mdr_q;
        kbsr_d       = kbsr_q;
        kbdr_d       = kbdr_q;
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (i_MIO_EN) begin
                    rw_d    = i_R_W;
                    state_d = is_io ? ST_DONE : ST_MEM;
                    if (io_rd) mdr_d = io_rdata;
                end else begin
                    if (i_LD_MAR) mar_d = i_Bus;
                    if (i_LD_MDR) mdr_d = i_Bus;
                end
            end
            ST_MEM: begin
                if (i_Mem_Ack) begin
                    state_d = ST_DONE;
                    if (!rw_q && i_LD_MDR) mdr_d = i_Mem_RData;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A KBDR read frees the buffer on the same edge, so a coincident key is still captured.
        if (i_KB_Valid && (!kbsr_q || kbdr_rd)) begin
            kbsr_d = 1'b1;
            kbdr_d = i_KB_Data;
        end else if (kbdr_rd) begin
            kbsr_d = 1'b0;
        end

        if (disp_valid_q && i_Disp_Ready) disp_valid_d = 1'b0;
        if (io_wr && (mar_q == DDR_ADDR) && !disp_valid_q) begin
            disp_valid_d = 1'b1;
            disp_data_d  = mdr_q[7:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            rw_q         <= 1'b0;
            mar_q        <= 16'h0000;
            mdr_q        <= 16'h0000;
            kbsr_q       <= 1'b0;
            kbdr_q       <= 8'h00;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            kbsr_q       <= kbsr_d;
            kbdr_q       <= kbdr_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    assign o_R          = (state_q == ST_DONE);
    assign o_Mem_Req    = (state_q == ST_MEM);
    assign o_Mem_We     = (state_q == ST_MEM) && rw_q;
    assign o_Mem_Addr   = mar_q;
    assign o_Mem_WData  = mdr_q;
    assign o_MAR        = mar_q;
    assign o_MDR        = mdr_q;
    assign o_Disp_Valid = disp_valid_q;
    assign o_Disp_Data  = disp_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction-level model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mmc;
    logic [15:0] adder;
    logic [7:0]  ir;
    logic [15:0] marmux;
    logic [15:0] bus;
    logic        ld_mar, ld_mdr, mio_en, r_w;
    logic        r;
    logic [15:0] mar, mdr;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;

    int passed = 0;
    int total  = 0;

    // Model: phase 0 = no access, 1 = waiting on memory, 2 = completion cycle
    int          m_phase;
    logic        m_write;
    logic [15:0] m_mar, m_mdr;
    logic        m_kbfull;
    logic [7:0]  m_kbdata;
    logic        m_dv;
    logic [7:0]  m_dd;

    mem_access_unit dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_MarMuxControl(mmc), .i_AdderMuxs(adder), .i_IR_7_0(ir), .o_MarMux_Out(marmux),
        .i_Bus(bus), .i_LD_MAR(ld_mar), .i_LD_MDR(ld_mdr), .i_MIO_EN(mio_en), .i_R_W(r_w),
        .o_R(r), .o_MAR(mar), .o_MDR(mdr),
        .o_Mem_Req(mem_req), .o_Mem_We(mem_we), .o_Mem_Addr(mem_addr), .o_Mem_WData(mem_wdata),
        .i_Mem_Ack(mem_ack), .i_Mem_RData(mem_rdata),
        .i_KB_Valid(kb_valid), .i_KB_Data(kb_data),
        .o_Disp_Valid(disp_valid), .o_Disp_Data(disp_data), .i_Disp_Ready(disp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    function automatic logic is_io(input logic [15:0] a);
        return a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_write = 0; m_mar = 0; m_mdr = 0;
        m_kbfull = 0; m_kbdata = 0; m_dv = 0; m_dd = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_step();
        logic old_dv, old_full, kbdr_read, ddr_write;
        old_dv = m_dv; old_full = m_kbfull; kbdr_read = 0; ddr_write = 0;
        if (m_phase == 0) begin
            if (mio_en) begin
                m_write = r_w;
                if (is_io(m_mar)) begin
                    m_phase = 2;
                    if (r_w) ddr_write = (m_mar == 16'hFE06);
                    else if (ld_mdr) begin
                        case (m_mar)
                            16'hFE00: m_mdr = old_full ? 16'h8000 : 16'h0000;
                            16'hFE02: begin m_mdr = {8'h00, m_kbdata}; kbdr_read = 1; end
                            16'hFE04: m_mdr = old_dv ? 16'h0000 : 16'h8000;
                            default:  m_mdr = 16'h0000;
                        endcase
                    end
                end else m_phase = 1;
            end else begin
                if (ld_mar) m_mar = bus;
                if (ld_mdr) m_mdr = bus;
            end
        end else if (m_phase == 1) begin
            if (mem_ack) begin
                if (!m_write && ld_mdr) m_mdr = mem_rdata;
                m_phase = 2;
            end
        end else m_phase = 0;

        if (old_dv && disp_ready) m_dv = 0;
        if (ddr_write && !old_dv) begin m_dv = 1; m_dd = m_mdr[7:0]; end
        if (kb_valid && (!old_full || kbdr_read)) begin m_kbfull = 1; m_kbdata = kb_data; end
        else if (kbdr_read) m_kbfull = 0;
    endtask

    task automatic compare_all();
        check("marmux",  marmux, mmc ? adder : {8'h00, ir});
        check("o_R",     16'(r), 16'(m_phase == 2));
        check("mem_req", 16'(mem_req), 16'(m_phase == 1));
        check("mem_we",  16'(mem_we), 16'(m_phase == 1 && m_write));
        check("mem_addr", mem_addr, m_mar);
        check("mem_wdata", mem_wdata, m_mdr);
        check("mar", mar, m_mar);
        check("mdr", mdr, m_mdr);
        check("disp_valid", 16'(disp_valid), 16'(m_dv));
        check("disp_data", 16'(disp_data), 16'(m_dd));
    endtask

    task automatic do_cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        mmc = 0; adder = 0; ir = 0; bus = 0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
        mem_ack = 0; mem_rdata = 0; kb_valid = 0; kb_data = 0; disp_ready = 0;
    endtask

    task automatic load_mar(input logic [15:0] v);
        bus = v; ld_mar = 1; do_cycle(); ld_mar = 0;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        bus = v; ld_mdr = 1; do_cycle(); ld_mdr = 0;
    endtask

    // I/O access to the address already in MAR; returns to idle afterwards.
    task automatic io_access(input logic rw);
        mio_en = 1; r_w = rw; ld_mdr = !rw;
        do_cycle();
        mio_en = 0; r_w = 0; ld_mdr = 0; kb_valid = 0;
        do_cycle();
    endtask

    task automatic strobe_key(input logic [7:0] k);
        kb_valid = 1; kb_data = k; do_cycle(); kb_valid = 0;
    endtask

    initial begin
        int req_cnt, r_cnt;
        logic [15:0] pool [7];
        pool = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFE08, 16'h3000, 16'hFE10};

        idle_inputs();
        rst_n = 0;
        m_reset();
        #3;
        check("rst_r", 16'(r), 16'h0);
        check("rst_req", 16'(mem_req), 16'h0);
        check("rst_mar", mar, 16'h0000);
        check("rst_mdr", mdr, 16'h0000);
        check("rst_dv", 16'(disp_valid), 16'h0);
        #9 rst_n = 1;
        do_cycle();

        // MARMUX selection
        ir = 8'h25; mmc = 0; #1 check("marmux_zext", marmux, 16'h0025);
        adder = 16'h3010; mmc = 1; #1 check("marmux_adder", marmux, 16'h3010);
        idle_inputs();

        // Memory read, ack on the third MEM cycle
        load_mar(16'h3000);
        mio_en = 1; r_w = 0; ld_mdr = 1; do_cycle(); mio_en = 0;
        req_cnt = 0; r_cnt = 0;
        for (int n = 0; n < 6; n++) begin
            mem_ack = (n == 2); mem_rdata = (n == 2) ? 16'hBEEF : 16'h5555; ld_mdr = (n <= 2);
            req_cnt += int'(mem_req); r_cnt += int'(r);
            do_cycle();
        end
        idle_inputs();
        check("rd_req_cycles", 16'(req_cnt), 16'd3);
        check("rd_r_pulses", 16'(r_cnt), 16'd1);
        check("rd_mdr", mdr, 16'hBEEF);
        check("rd_back_idle", 16'(mem_req | r), 16'h0);

        // Memory write, MAR load attempted mid-access
        load_mdr(16'h1234); load_mar(16'h4000);
        mio_en = 1; r_w = 1; do_cycle(); mio_en = 0; r_w = 0;
        for (int n = 0; n < 4; n++) begin
            mem_ack = (n == 1); ld_mar = (n == 0); bus = 16'hFFFF;
            if (n < 2) begin
                check("wr_we", 16'(mem_we), 16'h1);
                check("wr_addr", mem_addr, 16'h4000);
                check("wr_data", mem_wdata, 16'h1234);
            end
            do_cycle();
        end
        idle_inputs();
        check("wr_mar_kept", mar, 16'h4000);

        // Keyboard
        strobe_key(8'h41);
        load_mar(16'hFE00); io_access(0); check("kbsr_full", mdr, 16'h8000);
        load_mar(16'hFE02); io_access(0); check("kbdr_41", mdr, 16'h0041);
        load_mar(16'hFE00); io_access(0); check("kbsr_empty", mdr, 16'h0000);
        strobe_key(8'h41); strobe_key(8'h42);
        load_mar(16'hFE02); io_access(0); check("kb_drop", mdr, 16'h0041);
        strobe_key(8'h44);
        kb_valid = 1; kb_data = 8'h43; io_access(0); check("kb_sim_old", mdr, 16'h0044);
        load_mar(16'hFE00); io_access(0); check("kb_sim_full", mdr, 16'h8000);
        load_mar(16'hFE02); io_access(0); check("kb_sim_new", mdr, 16'h0043);

        // Display
        load_mdr(16'h0058); load_mar(16'hFE06); io_access(1);
        check("ddr_valid", 16'(disp_valid), 16'h1);
        check("ddr_data", 16'(disp_data), 16'h0058);
        load_mar(16'hFE04); io_access(0); check("dsr_busy", mdr, 16'h0000);
        load_mdr(16'h0059); load_mar(16'hFE06); io_access(1);
        check("ddr_drop", 16'(disp_data), 16'h0058);
        disp_ready = 1; do_cycle(); disp_ready = 0;
        check("disp_cleared", 16'(disp_valid), 16'h0);
        load_mar(16'hFE04); io_access(0); check("dsr_ready", mdr, 16'h8000);

        // Reset during MEM, then a late ack
        load_mar(16'h5000);
        mio_en = 1; r_w = 1; do_cycle(); mio_en = 0; r_w = 0;
        check("pre_rst_req", 16'(mem_req), 16'h1);
        #2 rst_n = 0; m_reset();
        #1;
        check("rst_mid_req", 16'(mem_req), 16'h0);
        check("rst_mid_we", 16'(mem_we), 16'h0);
        check("rst_mid_mar", mar, 16'h0000);
        check("rst_mid_mdr", mdr, 16'h0000);
        check("rst_mid_disp", 16'(disp_data), 16'h0000);
        #2 rst_n = 1;
        mem_ack = 1; do_cycle(); do_cycle(); mem_ack = 0;
        check("late_ack_no_r", 16'(r), 16'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            mmc        = 1'($urandom);
            adder      = 16'($urandom);
            ir         = 8'($urandom);
            bus        = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 6)];
            ld_mar     = ($urandom_range(0, 9) < 3);
            ld_mdr     = ($urandom_range(0, 9) < 6);
            mio_en     = ($urandom_range(0, 9) < 3);
            r_w        = 1'($urandom);
            mem_ack    = ($urandom_range(0, 9) < 4);
            mem_rdata  = 16'($urandom);
            kb_valid   = ($urandom_range(0, 9) < 2);
            kb_data    = 8'($urandom);
            disp_ready = ($urandom_range(0, 9) < 2);
            do_cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
